// File: rtl/sata_xfis_pkg.sv
// Shared types and constants for the SATA TX FIS arbiter.
//   xfis_arb_st_t : arbiter FSM states
//   DW_W          : FIS stream dword width
//   NREQ_MAX      : largest supported requester count
//   rr_next()     : round-robin pointer increment with wrap
package sata_xfis_pkg;

    localparam int unsigned DW_W     = 32;
    localparam int unsigned NREQ_MAX = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFwd,
        StWaitDone,
        StReplay
    } xfis_arb_st_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sata_xfis_arbiter_if.sv
// Bundles the requester-side FIS streams and the transport-side TX FIS stream.
//   req_tvalid/tlast/tdata  : requester streams, requester i on tdata[32*i+31:32*i]
//   req_tready/done/err     : per-requester handshake and completion status
//   xfis_tvalid/tlast/tdata : merged stream to the transport
//   xfis_tready/done/err    : transport handshake, end-of-transfer pulse, R_ERR qualifier
// Modports: master = environment (requesters + transport), slave = the arbiter.
interface sata_xfis_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    import sata_xfis_pkg::*;

    logic [NREQ-1:0]      req_tvalid;
    logic [NREQ-1:0]      req_tlast;
    logic [NREQ*DW_W-1:0] req_tdata;
    logic [NREQ-1:0]      req_tready;
    logic [NREQ-1:0]      req_done;
    logic [NREQ-1:0]      req_err;
    logic                 xfis_tvalid;
    logic                 xfis_tlast;
    logic [DW_W-1:0]      xfis_tdata;
    logic                 xfis_tready;
    logic                 xfis_done;
    logic                 xfis_err;

    modport master (
        output req_tvalid, req_tlast, req_tdata, xfis_tready, xfis_done, xfis_err,
        input  req_tready, req_done, req_err, xfis_tvalid, xfis_tlast, xfis_tdata
    );

    modport slave (
        input  req_tvalid, req_tlast, req_tdata, xfis_tready, xfis_done, xfis_err,
        output req_tready, req_done, req_err, xfis_tvalid, xfis_tlast, xfis_tdata
    );

endinterface

// File: rtl/sata_xfis_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit at or after
// ptr_i, wrapping past NREQ-1 back to 0.
//   req_i   : request vector
//   ptr_i   : search start index
//   found_o : any request set
//   idx_o   : selected index (0 when nothing is set)
module sata_xfis_rr_pick #(
    parameter int unsigned  NREQ = 4,
    localparam int unsigned IdxW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            found_o,
    output logic [IdxW-1:0] idx_o
);

    int unsigned j;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            j = 32'(ptr_i) + 32'(k);
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req_i[IdxW'(j)]) begin
                found_o = 1'b1;
                idx_o   = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/sata_xfis_arbiter.sv
// Shares the single TX FIS port of the link/transport core among NREQ requesters.
// Whole FISes are granted round-robin and forwarded unchanged; each requester
// gets a done/err pulse when its FIS is finished.
// Build option: define SATA_XFIS_RETRY_EN to buffer FISes of up to MAX_DW dwords
// and replay them (at most MAX_RETRY times) when the device answers R_ERR.
// Ports:
//   clk, rstn        : clock, async active-low reset
//   link_initialized : link up; no new grant while low
//   bus              : requester and transport streams (slave modport)
//   busy             : FSM not idle
//   grant_id         : current or last grantee
module sata_xfis_arbiter
    import sata_xfis_pkg::*;
#(
    parameter int unsigned  NREQ      = 4,
    parameter int unsigned  MAX_DW    = 16,
    parameter int unsigned  MAX_RETRY = 2,
    localparam int unsigned IdxW      = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 link_initialized,
    sata_xfis_arbiter_if.slave   bus,
    output logic                 busy,
    output logic [IdxW-1:0]      grant_id
);

    if (NREQ < 2 || NREQ > NREQ_MAX || MAX_DW < 1 || MAX_RETRY < 1) begin : g_param_err
        $error("sata_xfis_arbiter: parameter out of range");
    end

    xfis_arb_st_t    state_q;
    logic [IdxW-1:0] grant_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic [NREQ-1:0] done_q;
    logic [NREQ-1:0] err_q;

    logic            pick_found;
    logic [IdxW-1:0] pick_idx;
    logic            grant_ok;
    logic            g_valid;
    logic            g_last;
    logic [DW_W-1:0] g_data;
    logic            fwd_beat;
    logic            final_done;

    sata_xfis_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (bus.req_tvalid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign grant_ok = link_initialized && bus.xfis_tready && pick_found;
    assign g_valid  = bus.req_tvalid[grant_q];
    assign g_last   = bus.req_tlast[grant_q];
    assign g_data   = bus.req_tdata[32'(grant_q) * DW_W +: DW_W];
    assign fwd_beat = (state_q == StFwd) && g_valid && bus.xfis_tready;

`ifdef SATA_XFIS_RETRY_EN
    localparam int unsigned LenW = $clog2(MAX_DW) + 1;
    localparam int unsigned RdW  = (MAX_DW > 1) ? $clog2(MAX_DW) : 1;
    localparam int unsigned RetW = $clog2(MAX_RETRY + 1);

    logic [DW_W-1:0] buf_q [MAX_DW];
    logic [LenW-1:0] len_q;
    logic            ovf_q;
    logic [RetW-1:0] retry_q;
    logic [LenW-1:0] rd_q;
    logic            len_full;
    logic            rpl_last;

    assign len_full   = (len_q == LenW'(MAX_DW));
    assign rpl_last   = (rd_q == len_q - LenW'(1));
    assign final_done = !bus.xfis_err || ovf_q || (retry_q >= RetW'(MAX_RETRY));

    // Capture buffer: no reset, so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (fwd_beat && !len_full) begin
            buf_q[len_q[RdW-1:0]] <= g_data;
        end
    end
`else
    assign final_done = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            done_q   <= '0;
            err_q    <= '0;
`ifdef SATA_XFIS_RETRY_EN
            len_q    <= '0;
            ovf_q    <= 1'b0;
            retry_q  <= '0;
            rd_q     <= '0;
`endif
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                StIdle: begin
                    if (grant_ok) begin
                        grant_q <= pick_idx;
                        state_q <= StFwd;
`ifdef SATA_XFIS_RETRY_EN
                        len_q   <= '0;
                        ovf_q   <= 1'b0;
                        retry_q <= '0;
`endif
                    end
                end
                StFwd: begin
                    if (fwd_beat) begin
`ifdef SATA_XFIS_RETRY_EN
                        // Past MAX_DW the FIS can no longer be replayed.
                        if (len_full) begin
                            ovf_q <= 1'b1;
                        end else begin
                            len_q <= len_q + LenW'(1);
                        end
`endif
                        if (g_last) begin
                            state_q <= StWaitDone;
                        end
                    end
                end
                StWaitDone: begin
                    if (bus.xfis_done) begin
                        if (final_done) begin
                            done_q[grant_q] <= 1'b1;
                            err_q[grant_q]  <= bus.xfis_err;
                            // Pointer moves only on completion so a reset never skips anyone.
                            rr_ptr_q        <= IdxW'(rr_next(32'(grant_q), NREQ));
                            state_q         <= StIdle;
                        end
`ifdef SATA_XFIS_RETRY_EN
                        else begin
                            rd_q    <= '0;
                            state_q <= StReplay;
                        end
`endif
                    end
                end
`ifdef SATA_XFIS_RETRY_EN
                StReplay: begin
                    if (bus.xfis_tready) begin
                        if (rpl_last) begin
                            retry_q <= retry_q + RetW'(1);
                            state_q <= StWaitDone;
                        end else begin
                            rd_q <= rd_q + LenW'(1);
                        end
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.req_tready  = '0;
        bus.xfis_tvalid = 1'b0;
        bus.xfis_tlast  = 1'b0;
        bus.xfis_tdata  = '0;
        case (state_q)
            StFwd: begin
                bus.xfis_tvalid         = g_valid;
                bus.xfis_tlast          = g_last;
                bus.xfis_tdata          = g_data;
                bus.req_tready[grant_q] = bus.xfis_tready;
            end
`ifdef SATA_XFIS_RETRY_EN
            StReplay: begin
                bus.xfis_tvalid = 1'b1;
                bus.xfis_tlast  = rpl_last;
                bus.xfis_tdata  = buf_q[rd_q[RdW-1:0]];
            end
`endif
            default: ;
        endcase
    end

    assign bus.req_done = done_q;
    assign bus.req_err  = err_q;
    assign busy         = (state_q != StIdle);
    assign grant_id     = grant_q;

endmodule

// File: tb/tb_sata_xfis_arbiter.sv
// Directed bench for sata_xfis_arbiter: requester streams and a transport model
// are driven one cycle at a time; beats, grants and done pulses are logged at the
// falling edge and compared against hand-derived sequences.
module tb_sata_xfis_arbiter;
    import sata_xfis_pkg::*;

    localparam int unsigned NREQ = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       link_initialized = 1'b1;
    logic       busy;
    logic [1:0] grant_id;

    sata_xfis_arbiter_if #(.NREQ(NREQ)) bus ();

    sata_xfis_arbiter #(
        .NREQ      (NREQ),
        .MAX_DW    (16),
        .MAX_RETRY (2)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .link_initialized (link_initialized),
        .bus              (bus),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int unsigned rq_len  [NREQ];
    int unsigned rq_pos  [NREQ];
    int unsigned rq_left [NREQ];
    int unsigned rq_tag  [NREQ];
    bit          rq_gap  [NREQ];
    bit          rq_hold [NREQ];
    bit          fired   [NREQ];
    bit          tr_toggle;
    int unsigned done_cd;
    bit          err_script[$];
    logic [32:0] cap[$];
    int          grants[$];
    int          done_id[$];
    bit          done_err[$];
    bit          busy_prev;

    function automatic logic [31:0] dw(input int unsigned i, input int unsigned tag,
                                       input int unsigned pos);
        return {4'hA, i[3:0], tag[7:0], pos[15:0]};
    endfunction

    task automatic drive();
        for (int i = 0; i < int'(NREQ); i++) begin
            bus.req_tvalid[i]         = (rq_left[i] != 0) && !rq_hold[i];
            bus.req_tlast[i]          = (rq_pos[i] + 1 == rq_len[i]);
            bus.req_tdata[32*i +: 32] = dw(i, rq_tag[i], rq_pos[i]);
        end
    endtask

    // One clock: log at the falling edge, update requester/transport models after the rise.
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < int'(NREQ); i++) begin
            fired[i] = bus.req_tvalid[i] && bus.req_tready[i];
            if (bus.req_done[i]) begin
                done_id.push_back(i);
                done_err.push_back(bus.req_err[i]);
            end
        end
        if (bus.xfis_tvalid && bus.xfis_tready) begin
            cap.push_back({bus.xfis_tlast, bus.xfis_tdata});
            if (bus.xfis_tlast) done_cd = 2;
        end
        if (busy && !busy_prev) grants.push_back(int'(grant_id));
        busy_prev = busy;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (fired[i]) begin
                if (rq_pos[i] + 1 == rq_len[i]) begin
                    rq_pos[i]  = 0;
                    rq_left[i] = rq_left[i] - 1;
                    rq_tag[i]  = rq_tag[i] + 1;
                    rq_hold[i] = 1'b0;
                end else begin
                    rq_pos[i]  = rq_pos[i] + 1;
                    rq_hold[i] = rq_gap[i] && (rq_pos[i] % 2 == 1);
                end
            end else begin
                rq_hold[i] = 1'b0;
            end
        end
        bus.xfis_done = 1'b0;
        bus.xfis_err  = 1'b0;
        if (done_cd != 0) begin
            done_cd = done_cd - 1;
            if (done_cd == 0) begin
                bus.xfis_done = 1'b1;
                bus.xfis_err  = (err_script.size() > 0) ? err_script.pop_front() : 1'b0;
            end
        end
        if (tr_toggle) bus.xfis_tready = ~bus.xfis_tready;
        drive();
    endtask

    task automatic clear_logs();
        cap.delete();
        grants.delete();
        done_id.delete();
        done_err.delete();
        busy_prev = 1'b0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            rq_len[i]  = 1;
            rq_pos[i]  = 0;
            rq_left[i] = 0;
            rq_tag[i]  = 0;
            rq_gap[i]  = 1'b0;
            rq_hold[i] = 1'b0;
        end
        done_cd = 0;
        err_script.delete();
        tr_toggle        = 1'b0;
        bus.xfis_tready  = 1'b1;
        bus.xfis_done    = 1'b0;
        bus.xfis_err     = 1'b0;
        link_initialized = 1'b1;
        drive();
        cycle();
        cycle();
        rstn = 1'b1;
        clear_logs();
    endtask

    task automatic load(input int i, input int unsigned len, input int unsigned n);
        rq_len[i]  = len;
        rq_left[i] = n;
        rq_pos[i]  = 0;
        rq_hold[i] = 1'b0;
        drive();
    endtask

    task automatic test_reset();
        int g0;
        // Power-on: rstn has been low since time 0.
        @(negedge clk);
        checks++;
        if ({busy, grant_id, bus.xfis_tvalid, bus.xfis_tlast, bus.xfis_tdata} !== '0) begin
            errors++;
            $display("FAIL reset_xfis: got busy=%b gid=%0d v=%b l=%b d=%h expected all 0",
                     busy, grant_id, bus.xfis_tvalid, bus.xfis_tlast, bus.xfis_tdata);
        end
        checks++;
        if ({bus.req_tready, bus.req_done, bus.req_err} !== '0) begin
            errors++;
            $display("FAIL reset_req: got rdy=%b done=%b err=%b expected 0",
                     bus.req_tready, bus.req_done, bus.req_err);
        end
        apply_reset();
        load(1, 5, 1);
        for (int k = 0; k < 20 && cap.size() < 2; k++) cycle();
        checks++;
        if (cap.size() != 2) begin
            errors++;
            $display("FAIL reset_traffic: got %0d beats expected 2", cap.size());
        end
        load(0, 5, 1);
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy, grant_id, bus.xfis_tvalid, bus.req_tready} !== '0) begin
            errors++;
            $display("FAIL reset_midfis: got busy=%b gid=%0d v=%b rdy=%b expected 0",
                     busy, grant_id, bus.xfis_tvalid, bus.req_tready);
        end
        // Requester 1 resubmits its FIS from the start.
        rq_pos[1]  = 0;
        rq_hold[1] = 1'b0;
        done_cd    = 0;
        drive();
        cycle();
        checks++;
        if ({busy, bus.xfis_tvalid, bus.req_done} !== '0) begin
            errors++;
            $display("FAIL reset_held: got busy=%b v=%b done=%b expected 0",
                     busy, bus.xfis_tvalid, bus.req_done);
        end
        rstn = 1'b1;
        clear_logs();
        for (int k = 0; k < 100 && done_id.size() < 2; k++) cycle();
        g0 = (grants.size() > 0) ? grants[0] : -1;
        checks++;
        if (g0 != 0) begin
            errors++;
            $display("FAIL reset_first_grant: got %0d expected 0", g0);
        end
        checks++;
        if (cap.size() != 10 || cap[0] !== {1'b0, dw(0, 0, 0)}) begin
            errors++;
            $display("FAIL reset_after_data: got %0d beats first=%h expected 10 beats first=%h",
                     cap.size(), (cap.size() > 0) ? cap[0] : 33'h0, {1'b0, dw(0, 0, 0)});
        end
    endtask

    task automatic test_round_robin();
        int exp_id  [5] = '{0, 1, 2, 3, 0};
        int exp_tag [5] = '{0, 0, 0, 0, 1};
        logic [32:0] e;
        apply_reset();
        load(0, 5, 2);
        load(1, 5, 1);
        load(2, 5, 1);
        load(3, 5, 1);
        for (int k = 0; k < 400 && done_id.size() < 5; k++) cycle();
        repeat (10) cycle();
        checks++;
        if (done_id.size() != 5 || grants.size() != 5) begin
            errors++;
            $display("FAIL rr_counts: got dones=%0d grants=%0d expected 5 and 5",
                     done_id.size(), grants.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (grants[k] != exp_id[k] || done_id[k] != exp_id[k] || done_err[k] !== 1'b0)
                begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got grant=%0d done=%0d err=%b expected %0d/%0d/0",
                             k, grants[k], done_id[k], done_err[k], exp_id[k], exp_id[k]);
                end
            end
        end
        checks++;
        if (cap.size() != 25) begin
            errors++;
            $display("FAIL rr_beats: got %0d expected 25", cap.size());
        end else begin
            for (int k = 0; k < 25; k++) begin
                e = {(k % 5 == 4), dw(exp_id[k/5], exp_tag[k/5], k % 5)};
                checks++;
                if (cap[k] !== e) begin
                    errors++;
                    $display("FAIL rr_data[%0d]: got %h expected %h", k, cap[k], e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] e;
        apply_reset();
        tr_toggle  = 1'b1;
        rq_gap[1]  = 1'b1;
        load(1, 7, 1);
        for (int k = 0; k < 200 && done_id.size() < 1; k++) cycle();
        tr_toggle = 1'b0;
        checks++;
        if (done_id.size() != 1 || done_id[0] != 1) begin
            errors++;
            $display("FAIL bp_done: got %0d dones first=%0d expected one from 1",
                     done_id.size(), (done_id.size() > 0) ? done_id[0] : -1);
        end
        checks++;
        if (cap.size() != 7) begin
            errors++;
            $display("FAIL bp_beats: got %0d expected 7", cap.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                e = {(k == 6), dw(1, 0, k)};
                checks++;
                if (cap[k] !== e) begin
                    errors++;
                    $display("FAIL bp_data[%0d]: got %h expected %h", k, cap[k], e);
                end
            end
        end
    endtask

    task automatic test_gating();
        apply_reset();
        link_initialized = 1'b0;
        load(2, 4, 1);
        repeat (3) cycle();
        bus.xfis_done = 1'b1;  // stray pulse in IDLE must be ignored
        repeat (3) cycle();
        checks++;
        if (busy !== 1'b0 || bus.req_tready !== '0 || grants.size() != 0) begin
            errors++;
            $display("FAIL gate_hold: got busy=%b rdy=%b grants=%0d expected 0/0/0",
                     busy, bus.req_tready, grants.size());
        end
        checks++;
        if (done_id.size() != 0) begin
            errors++;
            $display("FAIL gate_stray_done: got %0d dones expected 0", done_id.size());
        end
        link_initialized = 1'b1;
        cycle();
        cycle();
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL gate_grant: got busy=%b gid=%0d expected 1/2", busy, grant_id);
        end
        link_initialized = 1'b0;  // dropping mid-FIS must not abort it
        for (int k = 0; k < 100 && done_id.size() < 1; k++) cycle();
        checks++;
        if (done_id.size() != 1 || cap.size() != 4 || done_id[0] != 2) begin
            errors++;
            $display("FAIL gate_complete: got dones=%0d beats=%0d expected 1 done from 2, 4 beats",
                     done_id.size(), cap.size());
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        load(0, 3, 1);
        load(1, 3, 1);
        for (int k = 0; k < 100 && done_id.size() < 1; k++) cycle();
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL b2b_grant: got busy=%b gid=%0d expected 1/1 after first done",
                     busy, grant_id);
        end
        for (int k = 0; k < 100 && done_id.size() < 2; k++) cycle();
        checks++;
        if (done_id.size() != 2 || done_id[0] != 0 || done_id[1] != 1) begin
            errors++;
            $display("FAIL b2b_done: got %0d dones expected 0 then 1", done_id.size());
        end
    endtask

`ifndef SATA_XFIS_RETRY_EN
    task automatic test_err_final();
        apply_reset();
        err_script = '{1'b1};
        load(3, 3, 1);
        for (int k = 0; k < 100 && done_id.size() < 1; k++) cycle();
        repeat (20) cycle();
        checks++;
        if (done_id.size() != 1 || done_id[0] != 3 || done_err[0] !== 1'b1) begin
            errors++;
            $display("FAIL err_final: got %0d dones expected one from 3 with err=1",
                     done_id.size());
        end
        checks++;
        if (cap.size() != 3 || grants.size() != 1) begin
            errors++;
            $display("FAIL err_noreplay: got beats=%0d grants=%0d expected 3/1",
                     cap.size(), grants.size());
        end
    endtask
`else
    task automatic test_retry();
        logic [32:0] e;
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            if (pass == 0) err_script = '{1'b1, 1'b1, 1'b0};
            else           err_script = '{1'b1, 1'b1, 1'b1};
            load(1, 5, 1);
            for (int k = 0; k < 300 && done_id.size() < 1; k++) cycle();
            repeat (10) cycle();
            checks++;
            if (done_id.size() != 1 || done_id[0] != 1 || done_err[0] !== (pass == 1)) begin
                errors++;
                $display("FAIL retry_done[%0d]: got %0d dones expected one from 1 with err=%0d",
                         pass, done_id.size(), pass);
            end
            checks++;
            if (cap.size() != 15) begin
                errors++;
                $display("FAIL retry_beats[%0d]: got %0d expected 15", pass, cap.size());
            end else begin
                for (int k = 0; k < 15; k++) begin
                    e = {(k % 5 == 4), dw(1, 0, k % 5)};
                    checks++;
                    if (cap[k] !== e) begin
                        errors++;
                        $display("FAIL retry_data[%0d][%0d]: got %h expected %h",
                                 pass, k, cap[k], e);
                    end
                end
            end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        err_script = '{1'b1};
        load(2, 20, 1);
        for (int k = 0; k < 200 && done_id.size() < 1; k++) cycle();
        repeat (20) cycle();
        checks++;
        if (done_id.size() != 1 || done_id[0] != 2 || done_err[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done: got %0d dones expected one from 2 with err=1",
                     done_id.size());
        end
        checks++;
        if (cap.size() != 20) begin
            errors++;
            $display("FAIL ovf_noreplay: got %0d beats expected 20", cap.size());
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < int'(NREQ); i++) begin
            rq_len[i]  = 1;
            rq_pos[i]  = 0;
            rq_left[i] = 0;
            rq_tag[i]  = 0;
            rq_gap[i]  = 1'b0;
            rq_hold[i] = 1'b0;
        end
        done_cd         = 0;
        tr_toggle       = 1'b0;
        busy_prev       = 1'b0;
        bus.xfis_tready = 1'b1;
        bus.xfis_done   = 1'b0;
        bus.xfis_err    = 1'b0;
        drive();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_gating();
        test_back_to_back();
`ifndef SATA_XFIS_RETRY_EN
        test_err_final();
`else
        test_retry();
        test_overflow();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
